// File: rtl/bcd_to_bin_dabble.sv
// Reverse double-dabble BCD-to-binary converter.
// Shifts {bcd,bin} right one bit per clock, correcting digits >= 8 by -3.
module bcd_to_bin_dabble #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  err
);

  localparam int BCD_W  = 4 * DIGITS;
  localparam int WORK_W = BCD_W + BIN_W;
  localparam int CNT_W  = $clog2(BIN_W + 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t            state_q, state_d;
  logic [WORK_W-1:0] work_q, work_d;
  logic [WORK_W-1:0] adj;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              bad;
  logic              done_d;
  logic [BIN_W-1:0]  bin_d;
  logic              erro_d;

  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_in[4*i +: 4] > 4'd9) bad = 1'b1;
    end
  end

  // One iteration: shift, then fix every BCD digit in parallel.
  always_comb begin
    adj = work_q >> 1;
    for (int i = 0; i < DIGITS; i++) begin
      if (adj[BIN_W+4*i +: 4] >= 4'd8)
        adj[BIN_W+4*i +: 4] = adj[BIN_W+4*i +: 4] - 4'd3;
    end
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    done_d  = 1'b0;
    bin_d   = bin_out;
    erro_d  = err;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          work_d  = {bcd_in, {BIN_W{1'b0}}};
          cnt_d   = CNT_W'(BIN_W);
          err_d   = bad;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        work_d = adj;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          bin_d   = err_q ? '0 : adj[BIN_W-1:0];
          erro_d  = err_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      done    <= 1'b0;
      bin_out <= '0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      done    <= done_d;
      bin_out <= bin_d;
      err     <= erro_d;
    end
  end

  assign busy = (state_q == SHIFT);

endmodule

// File: tb/tb_bcd_to_bin_dabble.sv
// Directed testbench for bcd_to_bin_dabble.
// Each task drives one scenario and checks outputs inline.
module tb_bcd_to_bin_dabble;

  logic        clk;
  logic        rst;
  logic        start;
  logic [11:0] bcd_in;
  logic        busy;
  logic        done;
  logic [9:0]  bin_out;
  logic        err;

  int checks;
  int errors;
  int cyc;

  bcd_to_bin_dabble #(.DIGITS(3), .BIN_W(10)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bcd_in  (bcd_in),
    .busy    (busy),
    .done    (done),
    .bin_out (bin_out),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Start a conversion and wait for done; lat is edges from start edge.
  task automatic do_conv(input logic [11:0] v, output int lat,
                         output int bc);
    @(negedge clk);
    start  = 1'b1;
    bcd_in = v;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    bc  = 0;
    while (lat < 20) begin
      if (done) break;
      if (busy) bc++;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst    = 1'b0;
    start  = 1'b0;
    bcd_in = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, err} !== 3'b000 || bin_out !== 10'd0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b err=%b bin=%0d want 0", busy,
               done, err, bin_out);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat, bc;
    do_conv(12'h255, lat, bc);
    checks++;
    if (lat !== 10) begin
      errors++;
      $display("FAIL basic_lat: got %0d want 10", lat);
    end
    checks++;
    if (bc !== 10) begin
      errors++;
      $display("FAIL basic_busy: got %0d want 10", bc);
    end
    checks++;
    if (bin_out !== 10'd255 || err !== 1'b0) begin
      errors++;
      $display("FAIL basic_val: got %0d/%b want 255/0", bin_out, err);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || bin_out !== 10'd255) begin
      errors++;
      $display("FAIL basic_pulse: done=%b bin=%0d want 0/255", done,
               bin_out);
    end
  endtask

  task automatic test_values();
    logic [11:0] vin [3] = '{12'h999, 12'h000, 12'h012};
    logic [9:0]  vexp[3] = '{10'd999, 10'd0, 10'd12};
    int lat, bc;
    for (int i = 0; i < 3; i++) begin
      do_conv(vin[i], lat, bc);
      checks++;
      if (lat !== 10 || bin_out !== vexp[i] || err !== 1'b0) begin
        errors++;
        $display("FAIL value_%h: got %0d/%b lat %0d want %0d/0 lat 10",
                 vin[i], bin_out, err, lat, vexp[i]);
      end
    end
  endtask

  task automatic test_err();
    int lat, bc;
    do_conv(12'h1A5, lat, bc);
    checks++;
    if (lat !== 10 || err !== 1'b1 || bin_out !== 10'd0) begin
      errors++;
      $display("FAIL err_flag: got %0d/%b lat %0d want 0/1 lat 10",
               bin_out, err, lat);
    end
    do_conv(12'h100, lat, bc);
    checks++;
    if (lat !== 10 || err !== 1'b0 || bin_out !== 10'd100) begin
      errors++;
      $display("FAIL err_clear: got %0d/%b lat %0d want 100/0 lat 10",
               bin_out, err, lat);
    end
  endtask

  task automatic test_ignore();
    int lat, extra;
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 12'h128;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (lat < 20) begin
      if (done) break;
      if (lat == 4) begin
        start  = 1'b1;
        bcd_in = 12'h777;
      end else if (lat == 5) begin
        start = 1'b0;
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    checks++;
    if (lat !== 10 || bin_out !== 10'd128) begin
      errors++;
      $display("FAIL ignore: got %0d lat %0d want 128 lat 10", bin_out,
               lat);
    end
    extra = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) extra++;
    end
    checks++;
    if (extra !== 0 || bin_out !== 10'd128) begin
      errors++;
      $display("FAIL ignore_queue: %0d extra done, bin %0d want 0/128",
               extra, bin_out);
    end
  endtask

  task automatic test_back_to_back();
    int n, c1, c2, extra;
    logic [9:0] r1, r2;
    n  = 0;
    c1 = 0;
    c2 = 0;
    r1 = '0;
    r2 = '0;
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 12'h042;
    for (int k = 0; k < 40 && n < 2; k++) begin
      @(negedge clk);
      if (done) begin
        n++;
        if (n == 1) begin
          r1     = bin_out;
          c1     = cyc;
          bcd_in = 12'h300;
        end else begin
          r2    = bin_out;
          c2    = cyc;
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    checks++;
    if (n !== 2 || r1 !== 10'd42 || r2 !== 10'd300) begin
      errors++;
      $display("FAIL b2b_vals: n=%0d r1=%0d r2=%0d want 2/42/300", n, r1,
               r2);
    end
    // Start edge sits one cycle after done, so pulses are 11 edges apart.
    checks++;
    if (c2 - c1 !== 11) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d want 11", c2 - c1);
    end
    extra = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL b2b_extra: got %0d want 0", extra);
    end
  endtask

  task automatic test_reset_mid();
    int lat, bc, extra;
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 12'h555;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if ({busy, done, err} !== 3'b000 || bin_out !== 10'd0) begin
      errors++;
      $display("FAIL mid_reset: busy=%b done=%b err=%b bin=%0d want 0",
               busy, done, err, bin_out);
    end
    @(negedge clk);
    rst = 1'b1;
    extra = 0;
    repeat (15) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL mid_abort: %0d busy/done cycles want 0", extra);
    end
    do_conv(12'h555, lat, bc);
    checks++;
    if (lat !== 10 || bin_out !== 10'd555 || err !== 1'b0) begin
      errors++;
      $display("FAIL mid_restart: got %0d/%b lat %0d want 555/0 lat 10",
               bin_out, err, lat);
    end
  endtask

  task automatic test_sweep();
    int lat, bc;
    logic [11:0] v;
    for (int n = 0; n < 1000; n++) begin
      v = {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
      do_conv(v, lat, bc);
      checks++;
      if (lat !== 10 || bin_out !== 10'(n) || err !== 1'b0) begin
        errors++;
        $display("FAIL sweep_%h: got %0d/%b lat %0d want %0d/0 lat 10", v,
                 bin_out, err, lat, n);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_values();
    test_err();
    test_ignore();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
